// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int   DATA_BITS  = 8;
    localparam int   STOP_BITS  = 1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. Push is ignored when full and pop
// is ignored when empty, so callers may drive them without extra gating.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed from a small byte FIFO.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for one bit period
// DATA  | data bits, LSB first, one bit period each
// STOP  | stop bit (high); chains directly into START if more bytes wait
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int CLKS_PER_BIT = 87,
    parameter  int FIFO_DEPTH   = 4,
    localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             uart_tx,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam int                IDX_W     = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

    tx_state_t            state;
    tx_state_t            state_next;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 uart_tx_d;
    logic                 baud_done;
    logic                 last_bit;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [7:0]           fifo_rdata;

    assign tx_ready  = !fifo_full;
    assign fifo_push = tx_valid && !fifo_full;
    assign baud_done = (baud_cnt == BAUD_LAST);
    assign last_bit  = (bit_idx == IDX_LAST);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (tx_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; every non-idle transition happens at the end of a bit period.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = START;
                end
            end
            START: begin
                if (baud_done) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (baud_done && last_bit) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (baud_done) begin
                    state_next = fifo_empty ? IDLE : START;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs: FIFO pop and the value the line register takes at the next edge.
    // The line level is derived from the state being entered so the line
    // changes on the same edge as the state.
    always_comb begin
        fifo_pop  = ((state == IDLE) || ((state == STOP) && baud_done)) && !fifo_empty;
        uart_tx_d = IDLE_LEVEL;
        case (state_next)
            START: uart_tx_d = 1'b0;
            DATA: begin
                if ((state == DATA) && baud_done) begin
                    uart_tx_d = shift_reg[1];
                end else begin
                    uart_tx_d = shift_reg[0];
                end
            end
            default: uart_tx_d = IDLE_LEVEL;
        endcase
        busy = (state != IDLE) || (fifo_count != '0);
    end

    // Baud counter, bit index and shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            if ((state == IDLE) || baud_done) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            if (state != DATA) begin
                bit_idx <= '0;
            end else if (baud_done) begin
                bit_idx <= bit_idx + 1'b1;
            end

            if (fifo_pop) begin
                shift_reg <= fifo_rdata;
            end else if ((state == DATA) && baud_done) begin
                shift_reg <= shift_reg >> 1;
            end
        end
    end

    // Registered serial line; reset forces it idle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_tx <= IDLE_LEVEL;
        end else begin
            uart_tx <= uart_tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: literal frame table, scripted corner cases and
// random traffic, all checked cycle by cycle against a frame-schedule model.
module tb_uart_tx_fifo;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    tx_data = 8'h00;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          uart_tx;
    logic          busy;
    logic [CW-1:0] fifo_count;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLKS_PER_BIT (N),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    int vectors     = 0;
    int miscompares = 0;
    int t           = 0;
    bit last_acc    = 1'b0;

    // Model: each accepted byte has an acceptance edge and a frame start edge.
    int         acc_q[$];
    int         st_q[$];
    logic [7:0] byte_q[$];

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit 0 is sent first
    } vec_t;
    vec_t vecs[5];

    function automatic int m_count(input int tt);
        int c = 0;
        foreach (acc_q[j]) begin
            if (acc_q[j] <= tt && tt < st_q[j]) c++;
        end
        return c;
    endfunction

    function automatic bit m_active(input int tt);
        foreach (st_q[j]) begin
            if (tt >= st_q[j] && tt < st_q[j] + 10 * N) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic m_line(input int tt);
        logic [7:0] b;
        int idx;
        foreach (st_q[j]) begin
            if (tt >= st_q[j] && tt < st_q[j] + 10 * N) begin
                idx = (tt - st_q[j]) / N;
                b   = byte_q[j];
                if (idx == 0) return 1'b0;
                if (idx == 9) return 1'b1;
                return b[idx-1];
            end
        end
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0d got %0h expected %0h", name, t, act, exp);
        end
    endtask

    // One clock: drive inputs, advance, update model, compare all outputs.
    task automatic step(input logic v, input logic [7:0] d);
        bit acc;
        int s;
        tx_valid = v;
        tx_data  = d;
        acc = v && (m_count(t) < D);
        @(posedge clk);
        #1;
        t++;
        if (acc) begin
            s = t + 1;
            if (st_q.size() > 0 && st_q[$] + 10 * N > s) s = st_q[$] + 10 * N;
            acc_q.push_back(t);
            st_q.push_back(s);
            byte_q.push_back(d);
        end
        last_acc = acc;
        tx_valid = 1'b0;
        check("uart_tx", uart_tx, m_line(t));
        check("fifo_count", fifo_count, m_count(t));
        check("tx_ready", tx_ready, m_count(t) < D);
        check("busy", busy, m_active(t) || m_count(t) > 0);
    endtask

    task automatic push(input logic [7:0] d);
        for (int i = 0; i < 500; i++) begin
            step(1'b1, d);
            if (last_acc) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL push_timeout byte %0h not accepted within 500 cycles", d);
    endtask

    task automatic idle_wait();
        for (int i = 0; i < 2000; i++) begin
            if (!m_active(t) && m_count(t) == 0) return;
            step(1'b0, 8'h00);
        end
        vectors++;
        miscompares++;
        $display("FAIL idle_timeout model still busy at t=%0d", t);
    endtask

    initial begin
        logic [9:0] fr;
        int         a;

        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h55, 10'b1010101010};
        vecs[4] = '{8'h81, 10'b1100000010};

        // Reset values.
        #12;
        check("rst_uart_tx", uart_tx, 1'b1);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_fifo_count", fifo_count, 0);
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle hold.
        for (int i = 0; i < 1000; i++) step(1'b0, 8'h00);

        // Literal frames, one byte at a time from idle.
        foreach (vecs[i]) begin
            idle_wait();
            fr = vecs[i].frame;
            push(vecs[i].data);
            check("pre_fall", uart_tx, 1'b1);
            for (int c = 1; c <= 10 * N; c++) begin
                step(1'b0, 8'h00);
                check("frame_bit", uart_tx, fr[(c-1)/N]);
                check("frame_busy", busy, 1'b1);
            end
            step(1'b0, 8'h00);
            check("busy_drop", busy, 1'b0);
        end

        // Back-to-back frames.
        idle_wait();
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        check("b2b_count", fifo_count, 2);
        idle_wait();

        // Full FIFO: sixth byte waits for space.
        for (int i = 0; i < 6; i++) begin
            push(8'h10 + 8'(i));
            if (i == 4) check("full_ready", tx_ready, 1'b0);
        end
        idle_wait();

        // Push landing on the stop-to-start edge with two bytes queued.
        push(8'hC1);
        a = st_q[$];
        push(8'hC2);
        push(8'hC3);
        while (t < a + 10 * N - 1) step(1'b0, 8'h00);
        step(1'b1, 8'hC4);
        check("simul_accept", last_acc, 1'b1);
        check("simul_count", fifo_count, 2);
        idle_wait();

        // Reset during data bit 3 of 0x3C with two bytes queued.
        push(8'h3C);
        a = st_q[$];
        push(8'h11);
        push(8'h22);
        while (t < a + 4 * N + 1) step(1'b0, 8'h00);
        check("pre_rst_count", fifo_count, 2);
        tx_valid = 1'b1;
        tx_data  = 8'h99;
        rst_n    = 1'b0;
        #1;
        check("arst_uart_tx", uart_tx, 1'b1);
        check("arst_fifo_count", fifo_count, 0);
        check("arst_tx_ready", tx_ready, 1'b1);
        check("arst_busy", busy, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_hold_count", fifo_count, 0);
        rst_n    = 1'b1;
        tx_valid = 1'b0;
        acc_q.delete();
        st_q.delete();
        byte_q.delete();
        for (int i = 0; i < 100; i++) step(1'b0, 8'h00);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) == 0, 8'($urandom));
        end
        idle_wait();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
